// File: rtl/pipe_scoreboard.sv
// Per-register latency scoreboard for the in-order pipeline: answers stall for the ID
// instruction and records accepted writes. Optional counters behind `SB_STATS_EN.
module pipe_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic             issue_wr_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREG-1:0]  busy_vec,
`ifdef SB_STATS_EN
  output logic [31:0]      stall_cycles,
  output logic [15:0]      waw_stalls,
`endif
  output logic [AW:0]      busy_cnt
);

  logic [LAT_W-1:0] cnt_reg  [NREG];
  logic [LAT_W-1:0] cnt_next [NREG];
  logic [LAT_W-1:0] rs_cnt, rt_cnt, rd_cnt;
  logic             raw, waw, load;

  // Register 0 never matches here, so r0 sources and destinations read as idle.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    rd_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue_rs == AW'(r)) rs_cnt = cnt_reg[r];
      if (issue_rt == AW'(r)) rt_cnt = cnt_reg[r];
      if (issue_rd == AW'(r)) rd_cnt = cnt_reg[r];
    end
  end

  assign raw = (issue_use_rs && (rs_cnt != '0)) || (issue_use_rt && (rt_cnt != '0));
  // A shorter-latency write may not overtake an older pending write to the same register.
  assign waw = issue_wr_en && (issue_rd != '0) && (issue_lat != '0) && (rd_cnt > issue_lat);

  assign stall      = reset && issue_valid && (raw || waw);
  assign issue_fire = issue_valid && !stall && !flush && !hold;
  assign load       = issue_fire && issue_wr_en && (issue_rd != '0) && (issue_lat != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      if (gi == 0) begin : g_r0
        assign cnt_next[gi] = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_rn
        // A same-cycle load wins over the decrement of its own entry.
        assign cnt_next[gi] = hold ? cnt_reg[gi] :
                              (load && (issue_rd == AW'(gi))) ? issue_lat :
                              (cnt_reg[gi] != '0) ? cnt_reg[gi] - LAT_W'(1) : '0;
        assign busy_vec[gi] = (cnt_reg[gi] != '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt_reg[r] <= '0;
      busy_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_reg[r] <= cnt_next[r];
      busy_cnt <= (AW+1)'($countones(busy_vec));
    end
  end

`ifdef SB_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] waw_stalls_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
      waw_stalls_reg   <= '0;
    end else begin
      if (stall && !hold && (stall_cycles_reg != '1)) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (stall && !raw && (waw_stalls_reg != '1))    waw_stalls_reg   <= waw_stalls_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign waw_stalls   = waw_stalls_reg;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: per-register countdown model compared every cycle,
// plus directed literal expectations. Stats ports checked when SB_STATS_EN is defined.
module tb_pipe_scoreboard;
  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0, use_rs = 1'b0, use_rt = 1'b0, wr_en = 1'b0;
  logic        flush = 1'b0, hold = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [2:0]  lat = '0;
  logic        stall, issue_fire;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;
`ifdef SB_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] waw_stalls;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  pipe_scoreboard #(.NREG(NREG), .AW(5), .LAT_W(3)) dut (
    .clk(clk), .reset(reset), .issue_valid(valid), .issue_rs(rs), .issue_rt(rt),
    .issue_use_rs(use_rs), .issue_use_rt(use_rt), .issue_wr_en(wr_en), .issue_rd(rd),
    .issue_lat(lat), .flush(flush), .hold(hold), .stall(stall), .issue_fire(issue_fire),
    .busy_vec(busy_vec),
`ifdef SB_STATS_EN
    .stall_cycles(stall_cycles), .waw_stalls(waw_stalls),
`endif
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: remaining cycles per register ----------------
  int m_cnt [NREG];
  int m_busy_cnt = 0;
  longint m_stall_cycles = 0, m_waw_stalls = 0;

  function automatic bit m_raw();
    return (use_rs && rs != 0 && m_cnt[rs] > 0) || (use_rt && rt != 0 && m_cnt[rt] > 0);
  endfunction
  function automatic bit m_waw();
    return wr_en && rd != 0 && lat != 0 && m_cnt[rd] > int'(lat);
  endfunction
  function automatic bit m_stall();
    return reset && valid && (m_raw() || m_waw());
  endfunction
  function automatic bit m_fire();
    return valid && !m_stall() && !flush && !hold;
  endfunction
  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) v[r] = 1'b1;
    return v;
  endfunction

  initial for (int r = 0; r < NREG; r++) m_cnt[r] = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_busy_cnt = 0;
      m_stall_cycles = 0;
      m_waw_stalls = 0;
    end else begin
      bit s, f, rw;
      s = m_stall();
      f = m_fire();
      rw = m_raw();
      m_busy_cnt = $countones(m_busy());
      if (s && !hold) m_stall_cycles++;
      if (s && !rw) m_waw_stalls++;
      if (!hold) begin
        for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
        if (f && wr_en && rd != 0 && lat != 0) m_cnt[rd] = int'(lat);
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", stall, m_stall());
    chk("issue_fire", issue_fire, m_fire());
    chk("busy_vec", busy_vec, m_busy());
    chk("busy_cnt", busy_cnt, m_busy_cnt);
`ifdef SB_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall_cycles);
    chk("waw_stalls", waw_stalls, m_waw_stalls);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input int s_rs, input int s_rt, input logic u_rs,
                       input logic u_rt, input logic w, input int d, input int l,
                       input logic f, input logic h);
    @(posedge clk);
    #2;
    valid = v; rs = 5'(s_rs); rt = 5'(s_rt); use_rs = u_rs; use_rt = u_rt;
    wr_en = w; rd = 5'(d); lat = 3'(l); flush = f; hold = h;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    idle();
    chk("rst_stall", stall, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    @(posedge clk); #2 reset = 1'b1;

    // Independent readers with nothing pending
    drive(1, 3, 4, 1, 1, 0, 0, 0, 0, 0);
    $display("tx plain read: stall=%0b fire=%0b", stall, issue_fire);
    chk("t1_stall", stall, 0);
    chk("t1_fire", issue_fire, 1);
    chk("t1_busy_vec", busy_vec, 0);
    chk("t1_busy_cnt", busy_cnt, 0);

    // Load-use on r5 with latency 2
    drive(1, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    chk("t2_fire", issue_fire, 1);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    $display("tx read r5 (cnt 2): stall=%0b", stall);
    chk("t2_stall_c2", stall, 1);
    chk("t2_busy5_c2", busy_vec[5], 1);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    $display("tx read r5 (cnt 1): stall=%0b", stall);
    chk("t2_stall_c1", stall, 1);
    chk("t2_busy_cnt", busy_cnt, 1);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    $display("tx read r5 (cnt 0): stall=%0b fire=%0b", stall, issue_fire);
    chk("t2_stall_c0", stall, 0);
    chk("t2_fire_c0", issue_fire, 1);
    chk("t2_busy5_c0", busy_vec[5], 0);

    // WAW: r7 lat 5 then r7 lat 1 waits until counter <= 1
    drive(1, 0, 0, 0, 0, 1, 7, 5, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
      if (!stall) break;
      n++;
    end
    $display("tx waw r7: stall cycles=%0d fire=%0b", n, issue_fire);
    chk("t3_waw_cycles", n, 4);
    chk("t3_fire", issue_fire, 1);
    idle();
    chk("t3_busy7_c1", busy_vec[7], 1);
    idle();
    chk("t3_busy7_c0", busy_vec[7], 0);

    // r0 is never tracked
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    chk("t4_fire", issue_fire, 1);
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    $display("tx r0 read: stall=%0b busy_vec=%0h", stall, busy_vec);
    chk("t4_stall", stall, 0);
    chk("t4_busy_vec", busy_vec, 0);

    // Hold freezes r9 at 2 for four cycles
    drive(1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 13, 2, 0, 1);
      $display("tx hold %0d: fire=%0b busy_vec=%0h", i, issue_fire, busy_vec);
      chk("t5_hold_fire", issue_fire, 0);
      chk("t5_hold_busy9", busy_vec[9], 1);
      chk("t5_hold_busy13", busy_vec[13], 0);
    end
    idle();
    chk("t5_busy9_c2", busy_vec[9], 1);
    idle();
    chk("t5_busy9_c1", busy_vec[9], 1);
    idle();
    chk("t5_busy9_c0", busy_vec[9], 0);

    // Flush blocks recording; stall still raised under flush
    drive(1, 0, 0, 0, 0, 1, 10, 2, 1, 0);
    chk("t6_flush_fire", issue_fire, 0);
    idle();
    chk("t6_flush_busy10", busy_vec[10], 0);

    // Two busy entries, rd==rs hazard, then reset mid-countdown
    drive(1, 0, 0, 0, 0, 1, 11, 7, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 12, 6, 0, 0);
    drive(1, 11, 12, 1, 1, 1, 11, 2, 1, 0);
    $display("tx rd==rs busy: stall=%0b busy_cnt=%0d", stall, busy_cnt);
    chk("t7_stall", stall, 1);
    chk("t7_busy_cnt", busy_cnt, 1);
    drive(1, 11, 12, 1, 1, 1, 11, 2, 0, 0);
    chk("t7_busy_vec", busy_vec, 32'h0000_1800);
    chk("t7_busy_cnt2", busy_cnt, 2);
    reset = 1'b0;
    #1;
    $display("tx reset: stall=%0b busy_vec=%0h busy_cnt=%0d", stall, busy_vec, busy_cnt);
    chk("t7_rst_stall", stall, 0);
    chk("t7_rst_busy_vec", busy_vec, 0);
    chk("t7_rst_busy_cnt", busy_cnt, 0);
`ifdef SB_STATS_EN
    chk("t7_rst_stall_cycles", stall_cycles, 0);
`endif
    idle();
    @(posedge clk); #2 reset = 1'b1;
    drive(1, 11, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t7_after_stall", stall, 0);
    chk("t7_after_fire", issue_fire, 1);

    idle();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: actual running expected finished");
    $fatal(1, "timeout");
  end
endmodule
